// File: rtl/swimmer_pkg.sv
// rtl/swimmer_pkg.sv - shared constants, FSM state type and sprite image for the swimmer drawer
package swimmer_pkg;

  localparam int SPRITE_W_DEF  = 11;
  localparam int SPRITE_H_DEF  = 17;
  localparam int SCREEN_W      = 160;
  localparam int SCREEN_H      = 120;
  localparam int BG_ROW_STRIDE = 160;

  localparam logic [2:0] COLOUR_TRANSPARENT = 3'b000;
  localparam logic [2:0] COLOUR_BLUE        = 3'b001;
  localparam logic [2:0] COLOUR_WHITE       = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } draw_state_t;

  // Sprite image as a fixed hash of the row-major pixel address; zero is the see-through colour.
  function automatic logic [2:0] sprite_rom_word(input logic [15:0] addr);
    return 3'(addr * 16'd13 + (addr >> 3));
  endfunction

endpackage

// File: rtl/swimmer_sprite_rom.sv
// rtl/swimmer_sprite_rom.sv - sprite image ROM, synchronous read with one cycle of latency
module swimmer_sprite_rom
  import swimmer_pkg::*;
#(
  parameter int DEPTH = SPRITE_W_DEF * SPRITE_H_DEF,
  parameter int AW    = 8
) (
  input  logic          clock,
  input  logic [AW-1:0] rom_addr_i,
  output logic [2:0]    rom_data_o
);

  logic [2:0] rom_data_q;

  always_ff @(posedge clock) begin
    if (int'(rom_addr_i) < DEPTH) rom_data_q <= sprite_rom_word(16'(rom_addr_i));
    else                          rom_data_q <= COLOUR_TRANSPARENT;
  end

  assign rom_data_o = rom_data_q;

endmodule

// File: rtl/swimmer_drawer.sv
// rtl/swimmer_drawer.sv - draws or erases the swimmer sprite into the frame buffer, one pixel per clock
// Optional horizontal mirroring (face_left input) is built when SWIMMER_MIRROR_EN is defined.
module swimmer_drawer
  import swimmer_pkg::*;
#(
  parameter int         SPRITE_W    = SPRITE_W_DEF,
  parameter int         SPRITE_H    = SPRITE_H_DEF,
  parameter logic [2:0] TRANSPARENT = COLOUR_TRANSPARENT
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic        erase,
  input  logic [7:0]  x_in,
  input  logic [6:0]  y_in,
  input  logic [8:0]  bY,
`ifdef SWIMMER_MIRROR_EN
  input  logic        face_left,
`endif
  output logic [16:0] bg_addr,
  input  logic [2:0]  bg_colour,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_write,
  output logic        busy,
  output logic        done
);

  localparam int CX_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CY_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int ROM_AW = $clog2(SPRITE_W * SPRITE_H);

  draw_state_t       state_q;
  logic [CX_W-1:0]   cx_q;
  logic [CY_W-1:0]   cy_q;
  logic [7:0]        x_q;
  logic [6:0]        y_q;
  logic [8:0]        by_q;
  logic              erase_q;
  logic              busy_q;
  logic              done_q;
  logic              p_wr_q;
  logic [7:0]        p_x_q;
  logic [6:0]        p_y_q;

  logic [8:0]        scr_x;
  logic [7:0]        scr_y;
  logic              in_scr;
  logic              last_col;
  logic              last_row;
  logic              accept;
  logic [CX_W-1:0]   rom_col;
  logic [ROM_AW-1:0] rom_addr;
  logic [2:0]        rom_data;

  assign scr_x    = {1'b0, x_q} + 9'(cx_q);
  assign scr_y    = {1'b0, y_q} + 8'(cy_q);
  assign in_scr   = (scr_x < 9'(SCREEN_W)) && (scr_y < 8'(SCREEN_H));
  assign last_col = (cx_q == CX_W'(SPRITE_W - 1));
  assign last_row = (cy_q == CY_W'(SPRITE_H - 1));
  assign accept   = (state_q == IDLE) && start && !busy_q;

  assign bg_addr = (17'(by_q) + 17'(y_q) + 17'(cy_q)) * 17'(BG_ROW_STRIDE) + 17'(scr_x);

`ifdef SWIMMER_MIRROR_EN
  logic face_left_q;
  assign rom_col = face_left_q ? (CX_W'(SPRITE_W - 1) - cx_q) : cx_q;
`else
  assign rom_col = cx_q;
`endif

  assign rom_addr = ROM_AW'(cy_q) * ROM_AW'(SPRITE_W) + ROM_AW'(rom_col);

  swimmer_sprite_rom #(
    .DEPTH (SPRITE_W * SPRITE_H),
    .AW    (ROM_AW)
  ) u_rom (
    .clock      (clock),
    .rom_addr_i (rom_addr),
    .rom_data_o (rom_data)
  );

  // Both ROMs answer one cycle after the pixel is issued, so the write stage pairs them with p_*_q.
  assign vga_write  = p_wr_q && (erase_q || (rom_data != TRANSPARENT));
  assign vga_colour = vga_write ? (erase_q ? bg_colour : rom_data) : 3'b000;
  assign vga_x      = p_x_q;
  assign vga_y      = p_y_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      by_q    <= '0;
      erase_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      p_wr_q  <= 1'b0;
      p_x_q   <= '0;
      p_y_q   <= '0;
`ifdef SWIMMER_MIRROR_EN
      face_left_q <= 1'b0;
`endif
    end else begin
      // busy stays up through the done cycle, which lands one cycle after FLUSH
      busy_q <= accept || (state_q != IDLE);
      done_q <= (state_q == FLUSH);
      p_wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            x_q     <= x_in;
            y_q     <= y_in;
            by_q    <= bY;
            erase_q <= erase;
`ifdef SWIMMER_MIRROR_EN
            face_left_q <= face_left;
`endif
            cx_q    <= '0;
            cy_q    <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          p_wr_q <= in_scr;
          p_x_q  <= scr_x[7:0];
          p_y_q  <= scr_y[6:0];
          if (last_col) begin
            cx_q <= '0;
            if (last_row) begin
              cy_q    <= '0;
              state_q <= FLUSH;
            end else begin
              cy_q <= cy_q + CY_W'(1);
            end
          end else begin
            cx_q <= cx_q + CX_W'(1);
          end
        end
        FLUSH:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_swimmer_drawer.sv
// tb/tb_swimmer_drawer.sv - randomized self-checking bench for swimmer_drawer against a pixel-list model
module tb_swimmer_drawer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        erase = 1'b0;
  logic [7:0]  x_in = '0;
  logic [6:0]  y_in = '0;
  logic [8:0]  bY = '0;
  logic        face_left = 1'b0;
  logic [16:0] bg_addr;
  logic [2:0]  bg_colour = '0;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_write;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_mis = 0;

  swimmer_drawer dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .erase      (erase),
    .x_in       (x_in),
    .y_in       (y_in),
    .bY         (bY),
`ifdef SWIMMER_MIRROR_EN
    .face_left  (face_left),
`endif
    .bg_addr    (bg_addr),
    .bg_colour  (bg_colour),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_write  (vga_write),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  function automatic int rom_model(input int a);
    return (a * 13 + a / 8) % 8;
  endfunction

  function automatic int bg_model(input int a);
    return (a * 5 + a / 64 + 3) % 8;
  endfunction

  // external background ROM: one cycle of read latency
  always @(posedge clock) bg_colour <= 3'(bg_model(int'(bg_addr)));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run_pass(input int x, input int y, input int by, input int er, input int face,
                          input int restart_at, input int abort_at, input string tag);
    logic [31:0] expq[$];
    logic [31:0] obs;
    int k = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int busy_bad = 0;
    int col;
    for (int cy = 0; cy < 17; cy++) begin
      for (int cx = 0; cx < 11; cx++) begin
        int sx = x + cx;
        int sy = y + cy;
        if (sx < 160 && sy < 120) begin
          if (er != 0) col = bg_model((by + y + cy) * 160 + sx);
          else         col = rom_model(cy * 11 + ((face != 0) ? 10 - cx : cx));
          if (er != 0 || col != 0) expq.push_back({5'd0, 9'(k + 2), 8'(sx), 7'(sy), 3'(col)});
        end
        k++;
      end
    end
    @(negedge clock);
    x_in = 8'(x); y_in = 7'(y); bY = 9'(by); erase = (er != 0); face_left = (face != 0);
    start = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      start = (restart_at > 0 && c == restart_at);
      if (start) begin
        x_in = 8'(x + 7); y_in = 7'(y + 3); erase = ~erase;
      end
      if (c == 1) check({tag, "_bg_addr0"}, bg_addr, 64'((by + y) * 160 + x));
      if ((c <= 189 && !busy) || (c >= 190 && busy)) busy_bad++;
      if (done) begin done_cnt++; done_cyc = c; end
      if (vga_write) begin
        obs = {5'd0, 9'(c), vga_x, vga_y, vga_colour};
        if (expq.size() == 0) check({tag, "_extra_write"}, obs, 64'd0);
        else                  check({tag, "_pix"}, obs, expq.pop_front());
      end
      if (abort_at > 0 && c == abort_at) begin
        resetn = 1'b0;
        #1;
        check({tag, "_rst_write"}, vga_write, 0);
        check({tag, "_rst_busy"}, busy, 0);
        check({tag, "_rst_outs"}, {done, vga_x, vga_y, vga_colour, bg_addr}, 0);
        for (int j = 0; j < 6; j++) begin
          @(negedge clock);
          if (done || vga_write) busy_bad++;
        end
        resetn = 1'b1;
        for (int j = 0; j < 6; j++) begin
          @(negedge clock);
          if (done || vga_write || busy) busy_bad++;
        end
        check({tag, "_post_rst_quiet"}, busy_bad, 0);
        return;
      end
    end
    check({tag, "_left_over"}, expq.size(), 0);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_done_cyc"}, done_cyc, 189);
    check({tag, "_busy"}, busy_bad, 0);
  endtask

  initial begin
    #1;
    check("reset_outs", {vga_write, busy, done, vga_x, vga_y, vga_colour}, 0);
    check("reset_bg_addr", bg_addr, 0);
    repeat (3) @(negedge clock);
    resetn = 1'b1;

    run_pass(80, 80, 0, 0, 0, 0, 0, "spr80");
    run_pass(10, 20, 280, 1, 0, 0, 0, "erase48010");
    run_pass(155, 110, 0, 0, 0, 0, 0, "edge_spr");
    run_pass(155, 110, 100, 1, 0, 0, 0, "edge_erase");
    run_pass(30, 40, 17, 0, 0, 50, 0, "restart");
    run_pass(20, 30, 0, 0, 0, 0, 102, "abort");
    run_pass(0, 0, 0, 0, 0, 0, 0, "post_abort");
`ifdef SWIMMER_MIRROR_EN
    run_pass(0, 5, 0, 0, 1, 0, 0, "mirror");
`endif
    for (int i = 0; i < 8; i++) begin
      int fc = 0;
`ifdef SWIMMER_MIRROR_EN
      fc = int'($urandom_range(0, 1));
`endif
      run_pass(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 511)), int'($urandom_range(0, 1)), fc, 0, 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
